// File: rtl/rx_fifo.sv
// Receive holding FIFO for one DUART channel. It buffers received characters, puts the head
// on the CPU bus during receive-holding-register reads, and pops when each read access ends.
module rx_fifo #(
    parameter int DEPTH = 3,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             cs,
    input  logic             rw,
    inout  wire  [WIDTH-1:0] data,
    input  logic             clr_err,
    output logic             RxRDY,
    output logic             FFULL,
    output logic             OE
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             oe_q, oe_d;
    logic             rd_q;

    logic rd, not_empty, full, pop, push, overrun;
    logic [WIDTH-1:0] head;

    assign rd        = cs && rw;
    assign not_empty = (count_q != '0);
    assign full      = (count_q == FULL_CNT);

    // A pop happens once per access, on the edge after the CPU releases the register.
    assign pop     = !rd && rd_q && not_empty;
    assign push    = wr_en && (!full || pop);
    assign overrun = wr_en && full && !pop;

    assign head = not_empty ? mem_q[rd_ptr_q] : '0;
    assign data = rd ? head : 'z;

    assign RxRDY = not_empty;
    assign FFULL = full;
    assign OE    = oe_q;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        oe_d     = oe_q;

        if (pop) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
        end
        if (push) begin
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // A new overrun on the same edge as clr_err leaves the flag set.
        if (clr_err) begin
            oe_d = 1'b0;
        end
        if (overrun) begin
            oe_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            oe_q     <= 1'b0;
            rd_q     <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            oe_q     <= oe_d;
            rd_q     <= rd;
        end
    end

    // The character array is not reset; only the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: tb/tb_rx_fifo.sv
// Directed bench for rx_fifo. Inputs change 1 time unit after each rising edge,
// and outputs are sampled before the next rising edge.
module tb_rx_fifo;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       cs;
    logic       rw;
    wire  [7:0] data;
    logic       clr_err;
    logic       RxRDY;
    logic       FFULL;
    logic       OE;

    int checks = 0;
    int errors = 0;

    rx_fifo #(.DEPTH(3), .WIDTH(8)) dut (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .cs      (cs),
        .rw      (rw),
        .data    (data),
        .clr_err (clr_err),
        .RxRDY   (RxRDY),
        .FFULL   (FFULL),
        .OE      (OE)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] v);
        wr_en   = 1'b1;
        wr_data = v;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic read_one(input string tag, input logic [7:0] exp);
        cs = 1'b1;
        rw = 1'b1;
        #1;
        check(tag, data, exp);
        tick();
        cs = 1'b0;
        tick();
    endtask

    initial begin
        reset = 1'b1; wr_en = 1'b0; wr_data = 8'h00;
        cs = 1'b0; rw = 1'b0; clr_err = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        check("reset_rxrdy", {7'b0, RxRDY}, 8'h00);
        check("reset_ffull", {7'b0, FFULL}, 8'h00);
        check("reset_oe",    {7'b0, OE},    8'h00);

        // Single character; the head must stay on the bus for a 3-cycle access.
        push(8'hA5);
        check("t1_rxrdy", {7'b0, RxRDY}, 8'h01);
        check("t1_ffull", {7'b0, FFULL}, 8'h00);
        cs = 1'b1; rw = 1'b1;
        #1; check("t1_data_c0", data, 8'hA5);
        tick(); check("t1_data_c1", data, 8'hA5);
        tick(); check("t1_data_c2", data, 8'hA5);
        check("t1_rxrdy_during", {7'b0, RxRDY}, 8'h01);
        tick();
        cs = 1'b0;
        tick();
        check("t1_rxrdy_after", {7'b0, RxRDY}, 8'h00);

        // Fill and drain in order.
        push(8'h11); push(8'h22);
        check("t2_ffull_2", {7'b0, FFULL}, 8'h00);
        push(8'h33);
        check("t2_ffull_3", {7'b0, FFULL}, 8'h01);
        read_one("t2_rd0", 8'h11);
        check("t2_ffull_pop1", {7'b0, FFULL}, 8'h00);
        check("t2_rxrdy_pop1", {7'b0, RxRDY}, 8'h01);
        read_one("t2_rd1", 8'h22);
        check("t2_rxrdy_pop2", {7'b0, RxRDY}, 8'h01);
        read_one("t2_rd2", 8'h33);
        check("t2_rxrdy_pop3", {7'b0, RxRDY}, 8'h00);

        // Overrun: the fourth character is discarded and OE is sticky.
        push(8'h01); push(8'h02); push(8'h03);
        check("t3_oe_full", {7'b0, OE}, 8'h00);
        push(8'h04);
        check("t3_oe_set", {7'b0, OE}, 8'h01);
        check("t3_ffull",  {7'b0, FFULL}, 8'h01);
        read_one("t3_rd0", 8'h01);
        read_one("t3_rd1", 8'h02);
        read_one("t3_rd2", 8'h03);
        check("t3_empty", {7'b0, RxRDY}, 8'h00);
        check("t3_oe_sticky", {7'b0, OE}, 8'h01);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check("t3_oe_clr", {7'b0, OE}, 8'h00);

        // Access ends on the same edge as a push into a full FIFO.
        push(8'h01); push(8'h02); push(8'h03);
        cs = 1'b1; rw = 1'b1;
        #1; check("t4_head", data, 8'h01);
        tick();
        cs = 1'b0;
        wr_en = 1'b1; wr_data = 8'h44;
        tick();
        wr_en = 1'b0;
        check("t4_oe",    {7'b0, OE},    8'h00);
        check("t4_ffull", {7'b0, FFULL}, 8'h01);
        read_one("t4_rd0", 8'h02);
        read_one("t4_rd1", 8'h03);
        read_one("t4_rd2", 8'h44);
        check("t4_empty", {7'b0, RxRDY}, 8'h00);

        // Read while empty: bus shows 0x00, and nothing underflows.
        cs = 1'b1; rw = 1'b1;
        #1; check("t5_data_empty", data, 8'h00);
        tick();
        cs = 1'b0;
        tick();
        check("t5_rxrdy", {7'b0, RxRDY}, 8'h00);
        check("t5_ffull", {7'b0, FFULL}, 8'h00);
        push(8'h55);
        read_one("t5_rd", 8'h55);
        check("t5_rxrdy_end", {7'b0, RxRDY}, 8'h00);

        // A register write access must not pop.
        push(8'h5A);
        cs = 1'b1; rw = 1'b0;
        tick(); tick();
        cs = 1'b0;
        tick();
        check("t7_write_nopop", {7'b0, RxRDY}, 8'h01);
        read_one("t7_rd", 8'h5A);

        // An overrun on the same edge as clr_err leaves OE set.
        push(8'h61); push(8'h62); push(8'h63);
        wr_en = 1'b1; wr_data = 8'h64; clr_err = 1'b1;
        tick();
        wr_en = 1'b0; clr_err = 1'b0;
        check("t8_set_wins", {7'b0, OE}, 8'h01);

        // Reset during a read access with entries held.
        read_one("t8_rd0", 8'h61);
        push(8'h77);
        cs = 1'b1; rw = 1'b1;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        cs = 1'b0;
        check("t6_rxrdy", {7'b0, RxRDY}, 8'h00);
        check("t6_ffull", {7'b0, FFULL}, 8'h00);
        check("t6_oe",    {7'b0, OE},    8'h00);
        tick();
        check("t6_no_underflow", {7'b0, RxRDY}, 8'h00);
        push(8'h88);
        check("t6_one_held", {7'b0, RxRDY}, 8'h01);
        read_one("t6_rd", 8'h88);
        check("t6_final_empty", {7'b0, RxRDY}, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
